// File: rtl/btn_pkg.sv
// Shared constants and helpers for the pushbutton debounce / event arbiter.
package btn_pkg;
    localparam int DEB_DEPTH     = 8;
    localparam int N_BTN_DEFAULT = 4;

    // Width of a button index; never narrower than one bit.
    function automatic int id_width(input int n_btn);
        return (n_btn > 1) ? $clog2(n_btn) : 1;
    endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: two-flop synchroniser, tick-sampled history and a
// level that only moves after DEB_DEPTH agreeing samples.
module btn_debounce_ch
    import btn_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level
);
    logic                 sync1_reg;
    logic                 sync2_reg;
    logic [DEB_DEPTH-1:0] hist_reg;
    logic                 level_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            hist_reg  <= '0;
            level_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (tick) begin
                hist_reg <= {hist_reg[DEB_DEPTH-2:0], sync2_reg};
            end
            // A mixed history means the contact is still bouncing: hold the level.
            if (&hist_reg) begin
                level_reg <= 1'b1;
            end else if (~|hist_reg) begin
                level_reg <= 1'b0;
            end
        end
    end

    assign level = level_reg;
endmodule

// File: rtl/btn_event_arbiter.sv
// Debounced pushbutton bank with a round-robin event queue and sticky overflow.
// Optional auto-repeat of held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN      = N_BTN_DEFAULT,
    parameter int TICK_DIV   = 100000,
    parameter int RPT_DELAY  = 500,
    parameter int RPT_PERIOD = 100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_BTN-1:0]           btn_raw,
    output logic [N_BTN-1:0]           btn_level,
    output logic                       evt_valid,
    output logic [id_width(N_BTN)-1:0] evt_id,
    output logic                       evt_repeat,
    input  logic                       evt_ready,
    output logic                       ovf
);
    localparam int ID_W   = id_width(N_BTN);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (N_BTN < 2 || N_BTN > 8 || TICK_DIV < 1 || RPT_PERIOD < 1 || RPT_PERIOD > RPT_DELAY) begin : g_cfg_err
        $error("btn_event_arbiter: unsupported parameter set");
    end

    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick;

    assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_debounce_ch u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .raw   (btn_raw[gi]),
            .level (btn_level[gi])
        );
    end

    logic [N_BTN-1:0] level_d_reg;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] rpt_fire;
    logic [N_BTN-1:0] set_evt;

    assign rise    = btn_level & ~level_d_reg;
    assign set_evt = rise | rpt_fire;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
    localparam int HOLD_W     = $clog2(RPT_DELAY + 1);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_rpt
        logic [HOLD_W-1:0] hold_cnt_reg;

        assign rpt_fire[gi] = tick && btn_level[gi] && (hold_cnt_reg == HOLD_W'(RPT_DELAY - 1));

        // After the first repeat the count restarts RPT_PERIOD short of the delay.
        always_ff @(posedge clk) begin
            if (rst || !btn_level[gi]) begin
                hold_cnt_reg <= '0;
            end else if (tick) begin
                hold_cnt_reg <= rpt_fire[gi] ? HOLD_W'(RPT_DELAY - RPT_PERIOD) : hold_cnt_reg + 1'b1;
            end
        end
    end
`else
    localparam bit AUTOREPEAT = 1'b0;
    assign rpt_fire = '0;
`endif

    logic [N_BTN-1:0] pending_reg, pending_next;
    logic [N_BTN-1:0] tag_reg, tag_next;
    logic [ID_W-1:0]  last_grant_reg;
    logic             evt_valid_reg;
    logic [ID_W-1:0]  evt_id_reg;
    logic             evt_repeat_reg;
    logic             ovf_reg;
    logic             load;
    logic             ovf_set;
    logic             hi_found;
    logic [ID_W-1:0]  hi_idx;
    logic [ID_W-1:0]  lo_idx;
    logic [ID_W-1:0]  grant_idx;

    assign load = (!evt_valid_reg || evt_ready) && (|pending_reg);

    // Round-robin: lowest pending index above last_grant, else lowest pending overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                lo_idx = ID_W'(i);
                if (ID_W'(i) > last_grant_reg) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
    end

    assign grant_idx = hi_found ? hi_idx : lo_idx;

    // A new event for a bit being granted this cycle refills it instead of overflowing.
    always_comb begin
        pending_next = pending_reg;
        tag_next     = tag_reg;
        ovf_set      = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (set_evt[i]) begin
                if (pending_reg[i] && !(load && grant_idx == ID_W'(i))) begin
                    ovf_set = 1'b1;
                end else begin
                    pending_next[i] = 1'b1;
                    tag_next[i]     = ~rise[i];
                end
            end else if (load && grant_idx == ID_W'(i)) begin
                pending_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_d_reg    <= '0;
            pending_reg    <= '0;
            tag_reg        <= '0;
            last_grant_reg <= ID_W'(N_BTN - 1);
            evt_valid_reg  <= 1'b0;
            evt_id_reg     <= '0;
            evt_repeat_reg <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            level_d_reg <= btn_level;
            pending_reg <= pending_next;
            tag_reg     <= tag_next;
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end
            if (load) begin
                evt_valid_reg  <= 1'b1;
                evt_id_reg     <= grant_idx;
                evt_repeat_reg <= tag_reg[grant_idx];
                last_grant_reg <= grant_idx;
            end else if (evt_valid_reg && evt_ready) begin
                evt_valid_reg <= 1'b0;
            end
        end
    end

    assign evt_valid  = evt_valid_reg;
    assign evt_id     = evt_id_reg;
    assign evt_repeat = evt_repeat_reg & AUTOREPEAT;
    assign ovf        = ovf_reg;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: directed scenarios plus random button/ready
// traffic, every cycle compared against a run-length/queue reference model.
module tb_btn_event_arbiter;
    localparam int NB = 4;
    localparam int TD = 4;
    localparam int RD = 6;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic          evt_valid;
    logic [1:0]    evt_id;
    logic          evt_repeat;
    logic          evt_ready;
    logic          ovf;

    btn_event_arbiter #(
        .N_BTN      (NB),
        .TICK_DIV   (TD),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_repeat (evt_repeat),
        .evt_ready  (evt_ready),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_id[$];
    bit acc_rep[$];
    int acc_cyc[$];

    // Reference model: debounce as runs of equal tick samples, events as pending flags.
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_lvl_d, m_pend, m_tag;
    int            m_ones[NB], m_zeros[NB], m_hold[NB];
    int            m_tcnt, m_last, m_id;
    logic          m_valid, m_rep, m_ovf;

    always @(posedge clk) begin : ref_model
        logic          tick, load;
        logic [NB-1:0] rise, fire;
        int            win, h;
        if (rst) begin
            m_tcnt = 0; m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0;
            m_pend = '0; m_tag = '0; m_valid = 1'b0; m_rep = 1'b0; m_ovf = 1'b0;
            m_id = 0; m_last = NB - 1;
            for (int i = 0; i < NB; i++) begin
                m_ones[i] = 0; m_zeros[i] = 8; m_hold[i] = 0;
            end
        end else begin
            tick = (m_tcnt == TD - 1);
            rise = m_lvl & ~m_lvl_d;
            fire = '0;
`ifdef BTN_AUTOREPEAT_EN
            for (int i = 0; i < NB; i++) begin
                if (tick && m_lvl[i]) begin
                    h = m_hold[i] + 1;
                    if (h >= RD && (h - RD) % RP == 0) fire[i] = 1'b1;
                end
            end
`endif
            load = (!m_valid || evt_ready) && (m_pend != '0);
            win = -1;
            for (int k = 1; k <= NB; k++) begin
                if (win < 0 && m_pend[(m_last + k) % NB]) win = (m_last + k) % NB;
            end
            if (load) begin
                m_valid = 1'b1; m_id = win; m_rep = m_tag[win]; m_last = win;
            end else if (m_valid && evt_ready) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NB; i++) begin
                if (rise[i] || fire[i]) begin
                    if (m_pend[i] && !(load && win == i)) m_ovf = 1'b1;
                    else begin m_pend[i] = 1'b1; m_tag[i] = !rise[i]; end
                end else if (load && win == i) begin
                    m_pend[i] = 1'b0;
                end
            end
            for (int i = 0; i < NB; i++) begin
                m_hold[i] = m_lvl[i] ? m_hold[i] + (tick ? 1 : 0) : 0;
            end
            m_lvl_d = m_lvl;
            for (int i = 0; i < NB; i++) begin
                if (m_ones[i] >= 8) m_lvl[i] = 1'b1;
                else if (m_zeros[i] >= 8) m_lvl[i] = 1'b0;
            end
            if (tick) begin
                for (int i = 0; i < NB; i++) begin
                    if (m_s2[i]) begin m_ones[i] = (m_ones[i] < 8) ? m_ones[i] + 1 : 8; m_zeros[i] = 0; end
                    else begin m_zeros[i] = (m_zeros[i] < 8) ? m_zeros[i] + 1 : 8; m_ones[i] = 0; end
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
            m_tcnt = tick ? 0 : m_tcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; log handshakes, then compare every output with the model.
    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                acc_id.push_back(int'(evt_id));
                acc_rep.push_back(evt_repeat);
                acc_cyc.push_back(cyc);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            chk("level", 32'(btn_level), 32'(m_lvl));
            chk("valid", 32'(evt_valid), 32'(m_valid));
            chk("id", 32'(evt_id), 32'(m_id));
            chk("repeat", 32'(evt_repeat), 32'(m_rep));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
    endtask

    task automatic clear_log();
        acc_id.delete();
        acc_rep.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_raw = '0; evt_ready = 1'b0;
        step(2);
        rst = 1'b0;
        clear_log();
    endtask

    initial begin
        int   bounce;
        logic [NB-1:0] base;

        rst = 1'b1; btn_raw = '0; evt_ready = 1'b0;
        step(3);
        rst = 1'b0;
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Steady press of button 2 debounces after 8 ticks and yields one press event.
        do_reset();
        evt_ready = 1'b1; btn_raw = 4'b0100;
        step(28);
        chk("s1_level_early", 32'(btn_level[2]), 32'd0);
        step(22);
        chk("s1_level", 32'(btn_level[2]), 32'd1);
        chk("s1_count", acc_id.size(), 1);
        chk("s1_id", acc_id[0], 2);
        chk("s1_rep", 32'(acc_rep[0]), 32'd0);
        btn_raw = '0;
        step(50);

        // Bouncing button 1 never settles.
        do_reset();
        evt_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            btn_raw[1] = ~btn_raw[1];
            step(3);
        end
        chk("s2_level", 32'(btn_level[1]), 32'd0);
        chk("s2_count", acc_id.size(), 0);
        btn_raw = '0;

        // Simultaneous presses of 0 and 3 are delivered back to back.
        do_reset();
        evt_ready = 1'b1; btn_raw = 4'b1001;
        step(45);
        chk("s3_count", 32'(acc_id.size() >= 2), 32'd1);
        chk("s3_first", acc_id[0], 0);
        chk("s3_second", acc_id[1], 3);
        chk("s3_b2b", acc_cyc[1] - acc_cyc[0], 1);
        btn_raw = '0;
        step(60);

        // Three presses of button 1 while the consumer stalls: the third is lost.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            btn_raw[1] = 1'b1;
            step(44);
`ifndef BTN_AUTOREPEAT_EN
            if (k < 2) chk("s4_ovf_early", 32'(ovf), 32'd0);
`endif
            if (k < 2) begin
                btn_raw[1] = 1'b0;
                step(44);
            end
        end
        chk("s4_ovf", 32'(ovf), 32'd1);
        evt_ready = 1'b1;
        step(10);
`ifdef BTN_AUTOREPEAT_EN
        chk("s4_any", 32'(acc_id.size() > 0), 32'd1);
`else
        chk("s4_count", acc_id.size(), 2);
`endif
        foreach (acc_id[k]) chk("s4_id", acc_id[k], 1);
        chk("s4_ovf_sticky", 32'(ovf), 32'd1);
        btn_raw = '0;
        step(50);

        // Long hold of button 0: one press, then repeats only when enabled.
        do_reset();
        evt_ready = 1'b1; btn_raw = 4'b0001;
        step(64);
        btn_raw = '0;
        step(60);
`ifdef BTN_AUTOREPEAT_EN
        chk("s5_count", acc_id.size(), 5);
        chk("s5_press", 32'(acc_rep[0]), 32'd0);
        for (int k = 1; k < 5; k++) chk("s5_rpt", 32'(acc_rep[k]), 32'd1);
        chk("s5_gap", acc_cyc[2] - acc_cyc[1], 12);
`else
        chk("s5_count", acc_id.size(), 1);
        chk("s5_press", 32'(acc_rep[0]), 32'd0);
`endif
        foreach (acc_id[k]) chk("s5_id", acc_id[k], 0);

        // Reset mid-handshake clears outputs and restores button 0 priority.
        do_reset();
        btn_raw = 4'b0001;
        step(45);
        chk("s6_valid_before", 32'(evt_valid), 32'd1);
        rst = 1'b1; btn_raw = '0;
        step(1);
        rst = 1'b0;
        chk("s6_level", 32'(btn_level), 32'd0);
        chk("s6_valid", 32'(evt_valid), 32'd0);
        chk("s6_id", 32'(evt_id), 32'd0);
        chk("s6_repeat", 32'(evt_repeat), 32'd0);
        chk("s6_ovf", 32'(ovf), 32'd0);
        clear_log();
        btn_raw = 4'b0011; evt_ready = 1'b1;
        step(50);
        chk("s6_first", acc_id[0], 0);
        chk("s6_second", acc_id[1], 1);
        btn_raw = '0;
        step(50);

        // Random bouncing buttons, random ready and rare resets.
        do_reset();
        base = '0; bounce = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                base = 4'($urandom_range(0, 15));
                bounce = 8;
            end
            if (bounce > 0) begin
                btn_raw = base ^ 4'($urandom_range(0, 15));
                bounce--;
            end else begin
                btn_raw = base;
            end
            evt_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 799) == 0);
            step(1);
        end
        rst = 1'b0;
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
